// File: rtl/top_pad_pkg.sv
// ----------------------------------------------------------------------------
// top_pad_pkg
// Shared types for the north pad-ring ownership controller:
//   - pad_state_e : controller FSM states
//   - owner_idx_t : 2-bit macro index (owner, rr pointer, lock id)
//   - NUM_MACROS_MAX / CFG_W : upper bound on requesters, pad-mux select width
//   - idx_to_onehot : index -> one-hot over NUM_MACROS_MAX bits
// Optional feature macro used by importers: PAD_OWNER_LOCK_EN.
// ----------------------------------------------------------------------------
package top_pad_pkg;

    localparam int unsigned NUM_MACROS_MAX = 4;
    localparam int unsigned CFG_W          = 4;

    typedef logic [1:0] owner_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        SWITCH,
        OWNED,
        DRAIN
    } pad_state_e;

    function automatic logic [NUM_MACROS_MAX-1:0] idx_to_onehot(input owner_idx_t idx);
        return {{(NUM_MACROS_MAX-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/top_rr_pick.sv
// ----------------------------------------------------------------------------
// top_rr_pick
// Combinational round-robin picker: first set bit of i_req, searching upward
// from i_rr_ptr and wrapping at NUM_MACROS.
// Ports:
//   i_req     in  NUM_MACROS  eligible requests
//   i_rr_ptr  in  2           index where the search starts
//   o_idx     out 2           winning index (0 when nothing requests)
//   o_valid   out 1           at least one request present
// ----------------------------------------------------------------------------
module top_rr_pick
    import top_pad_pkg::*;
#(
    parameter int unsigned NUM_MACROS = 4
) (
    input  logic [NUM_MACROS-1:0] i_req,
    input  owner_idx_t            i_rr_ptr,
    output owner_idx_t            o_idx,
    output logic                  o_valid
);

    logic [2:0] w_cand;

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int unsigned i = 0; i < NUM_MACROS; i++) begin
            w_cand = {1'b0, i_rr_ptr} + 3'(i);
            if (w_cand >= 3'(NUM_MACROS)) begin
                w_cand = w_cand - 3'(NUM_MACROS);
            end
            if (!o_valid && i_req[w_cand[1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[1:0];
            end
        end
    end

endmodule

// File: rtl/top_pad_owner_ctrl.sv
// ----------------------------------------------------------------------------
// top_pad_owner_ctrl
// Arbitrates ownership of the shared north pad ring between NUM_MACROS macros.
// Every ownership change goes DRAIN (oe_gate low, old select) -> SWITCH
// (oe_gate low, new select) -> OWNED, so two macros never drive the pads in
// the same cycle. All outputs are registered.
// Ports:
//   clk            in   1           block clock
//   rst_n          in   1           asynchronous active-low reset
//   req            in   NUM_MACROS  level request per macro
//   lock_en        in   1           (PAD_OWNER_LOCK_EN only) restrict to lock_id
//   lock_id        in   2           (PAD_OWNER_LOCK_EN only) locked macro index
//   grant          out  NUM_MACROS  one-hot, high only in OWNED
//   configuration  out  4           pad-mux select = owner index, zero-extended
//   oe_gate        out  1           0 forces all pads to input
//   busy           out  1           high in SWITCH or DRAIN
// Optional feature macro: PAD_OWNER_LOCK_EN.
// ----------------------------------------------------------------------------
module top_pad_owner_ctrl
    import top_pad_pkg::*;
#(
    parameter int unsigned NUM_MACROS    = 4,
    parameter int unsigned DEAD_CYCLES   = 2,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned MAX_HOLD      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_MACROS-1:0] req,
`ifdef PAD_OWNER_LOCK_EN
    input  logic                  lock_en,
    input  owner_idx_t            lock_id,
`endif
    output logic [NUM_MACROS-1:0] grant,
    output logic [CFG_W-1:0]      configuration,
    output logic                  oe_gate,
    output logic                  busy
);

    localparam int unsigned CNT_MAX = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned HOLD_W  = $clog2(MAX_HOLD + 2);

    localparam logic [CNT_W-1:0]  DEAD_LOAD   = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(MAX_HOLD - 1);

    pad_state_e           r_state,  w_state_nxt;
    owner_idx_t           r_owner,  w_owner_nxt;
    owner_idx_t           r_rr_ptr, w_rr_nxt;
    logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
    logic [HOLD_W-1:0]    r_hold,   w_hold_nxt;
    logic [NUM_MACROS-1:0] r_grant;
    logic                 r_oe;
    logic                 r_busy;

    logic [NUM_MACROS_MAX-1:0] w_owner_oh_full;
    logic [NUM_MACROS-1:0]     w_owner_oh;
    logic [NUM_MACROS-1:0]     w_req_eff;
    logic                      w_preempt_en;
    logic                      w_owner_req;
    logic                      w_other_req;
    owner_idx_t                w_pick_idx;
    logic                      w_pick_valid;

    assign w_owner_oh_full = idx_to_onehot(r_owner);
    assign w_owner_oh      = w_owner_oh_full[NUM_MACROS-1:0];

`ifdef PAD_OWNER_LOCK_EN
    logic [NUM_MACROS_MAX-1:0] w_lock_oh_full;
    assign w_lock_oh_full = idx_to_onehot(lock_id);
    // Masking the request vector makes a foreign owner look released, which
    // is what forces OWNED->DRAIN when a lock arrives.
    assign w_req_eff    = lock_en ? (req & w_lock_oh_full[NUM_MACROS-1:0]) : req;
    assign w_preempt_en = (MAX_HOLD != 0) && !lock_en;
`else
    assign w_req_eff    = req;
    assign w_preempt_en = (MAX_HOLD != 0);
`endif

    assign w_owner_req = |(w_req_eff & w_owner_oh);
    assign w_other_req = |(w_req_eff & ~w_owner_oh);

    top_rr_pick #(
        .NUM_MACROS (NUM_MACROS)
    ) u_rr_pick (
        .i_req    (w_req_eff),
        .i_rr_ptr (r_rr_ptr),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_cnt;
        w_hold_nxt  = r_hold;
        unique case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = SWITCH;
                    w_owner_nxt = w_pick_idx;
                    w_cnt_nxt   = SETTLE_LOAD;
                end
            end
            SWITCH: begin
                if (!w_owner_req) begin
                    w_state_nxt = DRAIN;
                    w_cnt_nxt   = DEAD_LOAD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = OWNED;
                    w_hold_nxt  = '0;
                    w_rr_nxt    = (r_owner == owner_idx_t'(NUM_MACROS - 1)) ? '0 : r_owner + 2'd1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            OWNED: begin
                if (!w_owner_req) begin
                    w_state_nxt = DRAIN;
                    w_cnt_nxt   = DEAD_LOAD;
                    w_hold_nxt  = '0;
                end else if (w_other_req) begin
                    if (w_preempt_en && (r_hold == HOLD_LAST)) begin
                        w_state_nxt = DRAIN;
                        w_cnt_nxt   = DEAD_LOAD;
                        w_hold_nxt  = '0;
                    end else if (r_hold != '1) begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end else begin
                    w_hold_nxt = '0;
                end
            end
            DRAIN: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (w_pick_valid) begin
                    w_state_nxt = SWITCH;
                    w_owner_nxt = w_pick_idx;
                    w_cnt_nxt   = SETTLE_LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs decode the next state so grant/oe_gate change on the same edge
    // as the state itself; grant uses r_owner, which is stable across SWITCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_hold   <= '0;
            r_grant  <= '0;
            r_oe     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hold   <= w_hold_nxt;
            r_grant  <= (w_state_nxt == OWNED) ? w_owner_oh : '0;
            r_oe     <= (w_state_nxt == OWNED);
            r_busy   <= (w_state_nxt == SWITCH) || (w_state_nxt == DRAIN);
        end
    end

    assign grant         = r_grant;
    assign configuration = {{(CFG_W-2){1'b0}}, r_owner};
    assign oe_gate       = r_oe;
    assign busy          = r_busy;

endmodule

// File: tb/tb_top_pad_owner_ctrl.sv
// ----------------------------------------------------------------------------
// tb_top_pad_owner_ctrl
// Directed testbench for top_pad_owner_ctrl (DEAD=2, SETTLE=1, MAX_HOLD=4).
// Lock scenario is compiled only with PAD_OWNER_LOCK_EN defined.
// ----------------------------------------------------------------------------
module tb_top_pad_owner_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] configuration;
    logic       oe_gate;
    logic       busy;
`ifdef PAD_OWNER_LOCK_EN
    logic       lock_en;
    logic [1:0] lock_id;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    top_pad_owner_ctrl #(
        .NUM_MACROS    (4),
        .DEAD_CYCLES   (2),
        .SETTLE_CYCLES (1),
        .MAX_HOLD      (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
`ifdef PAD_OWNER_LOCK_EN
        .lock_en       (lock_en),
        .lock_id       (lock_id),
`endif
        .grant         (grant),
        .configuration (configuration),
        .oe_gate       (oe_gate),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] exp_g, input logic [3:0] exp_c,
                              input logic exp_oe, input logic exp_busy);
        check({tag, "/grant"}, 32'(grant), 32'(exp_g));
        check({tag, "/cfg"},   32'(configuration), 32'(exp_c));
        check({tag, "/oe"},    32'(oe_gate), 32'(exp_oe));
        check({tag, "/busy"},  32'(busy), 32'(exp_busy));
    endtask

    // Continuous safety checks: one-hot grant, oe_gate tracks grant,
    // select stable while driving, dead time before a select change,
    // oe_gate rising only on a select already held for a cycle.
    logic [3:0] prev_cfg = '0;
    logic       prev_oe  = 1'b0;
    int         low_run  = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("mon.onehot0", 32'($onehot0(grant)), 32'd1);
            check("mon.oe_vs_grant", 32'(oe_gate), 32'(|grant));
            if (oe_gate && prev_oe)
                check("mon.cfg_stable", 32'(configuration), 32'(prev_cfg));
            if (oe_gate && !prev_oe)
                check("mon.settle", 32'(configuration), 32'(prev_cfg));
            if (configuration != prev_cfg)
                check("mon.dead_time", 32'(low_run >= 2), 32'd1);
        end
        prev_cfg <= configuration;
        prev_oe  <= oe_gate;
        low_run  <= oe_gate ? 0 : low_run + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
`ifdef PAD_OWNER_LOCK_EN
        lock_en = 1'b0;
        lock_id = 2'd0;
`endif
        step();
        step();
        expect_out("reset", 4'b0000, 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Single requester: SWITCH next cycle, grant the one after, then held
        req = 4'b0001;
        step(); expect_out("t1.switch", 4'b0000, 4'd0, 1'b0, 1'b1);
        step(); expect_out("t1.owned",  4'b0001, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(); expect_out($sformatf("t1.hold%0d", i), 4'b0001, 4'd0, 1'b1, 1'b0);
        end

        // Handoff 0 -> 2: two dead cycles on old select, one settle on new
        req = 4'b0100;
        step(); expect_out("t2.drain0", 4'b0000, 4'd0, 1'b0, 1'b1);
        step(); expect_out("t2.drain1", 4'b0000, 4'd0, 1'b0, 1'b1);
        step(); expect_out("t2.switch", 4'b0000, 4'd2, 1'b0, 1'b1);
        step(); expect_out("t2.owned",  4'b0100, 4'd2, 1'b1, 1'b0);

        // Release to IDLE: select keeps last owner
        req = 4'b0000;
        step(); expect_out("t2.rel0", 4'b0000, 4'd2, 1'b0, 1'b1);
        step(); expect_out("t2.rel1", 4'b0000, 4'd2, 1'b0, 1'b1);
        step(); expect_out("t2.idle0", 4'b0000, 4'd2, 1'b0, 1'b0);
        step(); expect_out("t2.idle1", 4'b0000, 4'd2, 1'b0, 1'b0);

        // Abort during SWITCH (rr_ptr=3 -> macro 1 wins)
        req = 4'b0010;
        step(); expect_out("t4.switch", 4'b0000, 4'd1, 1'b0, 1'b1);
        req = 4'b0000;
        step(); expect_out("t4.drain0", 4'b0000, 4'd1, 1'b0, 1'b1);
        step(); expect_out("t4.drain1", 4'b0000, 4'd1, 1'b0, 1'b1);
        step(); expect_out("t4.idle",   4'b0000, 4'd1, 1'b0, 1'b0);

        // Asynchronous reset returns select to 0 without a clock edge
        rst_n = 1'b0;
        #1;
        expect_out("t3.areset", 4'b0000, 4'd0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;

        // All four requesting: preemption after 4 owned cycles, strict rotation
        req = 4'b1111;
        step(); expect_out("t3.switch", 4'b0000, 4'd0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                step();
                expect_out($sformatf("t3.o%0d.c%0d", k, j), 4'(1 << k), 4'(k), 1'b1, 1'b0);
            end
            step(); expect_out($sformatf("t3.o%0d.d0", k), 4'b0000, 4'(k), 1'b0, 1'b1);
            step(); expect_out($sformatf("t3.o%0d.d1", k), 4'b0000, 4'(k), 1'b0, 1'b1);
            step(); expect_out($sformatf("t3.o%0d.sw", k), 4'b0000, 4'((k + 1) % 4), 1'b0, 1'b1);
        end
        step(); expect_out("t3.wrap0", 4'b0001, 4'd0, 1'b1, 1'b0);
        step(); expect_out("t3.wrap1", 4'b0001, 4'd0, 1'b1, 1'b0);

        // Reset mid-OWNED, asserted between clock edges
        #3;
        rst_n = 1'b0;
        #1;
        expect_out("t5.areset", 4'b0000, 4'd0, 1'b0, 1'b0);
        req = 4'b0000;
        step();
        step();
        rst_n = 1'b1;

        // Release and new requests together: release wins, rr picks macro 1
        req = 4'b0001;
        step(); expect_out("t7.switch", 4'b0000, 4'd0, 1'b0, 1'b1);
        step(); expect_out("t7.owned",  4'b0001, 4'd0, 1'b1, 1'b0);
        req = 4'b0110;
        step(); expect_out("t7.drain0", 4'b0000, 4'd0, 1'b0, 1'b1);
        step(); expect_out("t7.drain1", 4'b0000, 4'd0, 1'b0, 1'b1);
        step(); expect_out("t7.switch1", 4'b0000, 4'd1, 1'b0, 1'b1);
        req = 4'b0010;
        step(); expect_out("t7.owned1", 4'b0010, 4'd1, 1'b1, 1'b0);

`ifdef PAD_OWNER_LOCK_EN
        // Lock to macro 3 while macro 1 owns: forced handoff, no preemption
        req     = 4'b1010;
        lock_en = 1'b1;
        lock_id = 2'd3;
        step(); expect_out("t6.drain0", 4'b0000, 4'd1, 1'b0, 1'b1);
        step(); expect_out("t6.drain1", 4'b0000, 4'd1, 1'b0, 1'b1);
        step(); expect_out("t6.switch", 4'b0000, 4'd3, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(); expect_out($sformatf("t6.hold%0d", i), 4'b1000, 4'd3, 1'b1, 1'b0);
        end
        lock_en = 1'b0;
`endif

        req = 4'b0000;
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
